exu_mem_arb: RTL and testbench

- Shares one memory bus master port between instruction fetch (IF) and the execution unit's load/store path (LS).
- Sits between the fetch unit / exu ldst request-response ports and the core bus.
- Arbitrates requests and tracks outstanding transactions in grant order.
- Routes in-order bus responses back to the originating requester.

---
 rtl/exu_mem_arb_pkg.sv | 19 +
 rtl/exu_mem_arb_fifo.sv | 58 +++++
 rtl/exu_mem_arb.sv | 136 +++++++++++++
 tb/tb_exu_mem_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package exu_mem_arb_pkg;

  typedef enum logic {
    ARB_ID_IF = 1'b0,
    ARB_ID_LS = 1'b1
  } mem_arb_id_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } mem_arb_state_e;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/exu_mem_arb_fifo.sv
// Grant-order ID FIFO: synchronous, DEPTH entries, supports push and pop in the same cycle.
module exu_mem_arb_fifo
  import exu_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  mem_arb_id_e   push_id_i,
  input  logic          pop_i,
  output mem_arb_id_e   head_id_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  mem_arb_id_e   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_id_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= inc_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= inc_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/exu_mem_arb.sv
// Arbitrates fetch and load/store onto one bus master port, routing in-order responses back.
// Define EXU_MEM_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module exu_mem_arb
  import exu_mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_vld,
  output logic            if_req_rdy,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_vld,
  output logic [DW-1:0]   if_rsp_rdata,
  input  logic            ls_req_vld,
  output logic            ls_req_rdy,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic            ls_req_wr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wstrb,
  output logic            ls_rsp_vld,
  output logic [DW-1:0]   ls_rsp_rdata,
  output logic            bus_req_vld,
  input  logic            bus_req_rdy,
  output logic [AW-1:0]   bus_req_addr,
  output logic            bus_req_wr,
  output logic [DW-1:0]   bus_req_wdata,
  output logic [DW/8-1:0] bus_req_wstrb,
  input  logic            bus_rsp_vld,
  input  logic [DW-1:0]   bus_rsp_rdata
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  mem_arb_state_e state_q, state_d;
  mem_arb_id_e    win_q, win_d;
  mem_arb_id_e    pick, sel, head_id;
  logic [CW-1:0]  outst_cnt;
  logic           fifo_full, fifo_empty;
  logic           grant_ok, hs, push, pop;

  assign grant_ok = (outst_cnt < CW'(MAX_OUTST));

`ifdef EXU_MEM_ARB_RR_EN
  mem_arb_id_e rr_q, rr_d;

  // rr_q names the requester that wins when both are valid.
  always_comb begin
    if (if_req_vld && ls_req_vld) pick = rr_q;
    else                          pick = ls_req_vld ? ARB_ID_LS : ARB_ID_IF;
    rr_d = rr_q;
    if (hs) rr_d = (sel == ARB_ID_LS) ? ARB_ID_IF : ARB_ID_LS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= ARB_ID_IF;
    else        rr_q <= rr_d;
  end
`else
  assign pick = ls_req_vld ? ARB_ID_LS : ARB_ID_IF;
`endif

  always_comb begin
    sel           = (state_q == ARB_HOLD) ? win_q : pick;
    bus_req_vld   = (state_q == ARB_HOLD) || (grant_ok && (if_req_vld || ls_req_vld));
    bus_req_addr  = '0;
    bus_req_wr    = 1'b0;
    bus_req_wdata = '0;
    bus_req_wstrb = '0;
    if (bus_req_vld) begin
      if (sel == ARB_ID_LS) begin
        bus_req_addr  = ls_req_addr;
        bus_req_wr    = ls_req_wr;
        bus_req_wdata = ls_req_wdata;
        bus_req_wstrb = ls_req_wstrb;
      end else begin
        bus_req_addr  = if_req_addr;
      end
    end
    hs         = bus_req_vld && bus_req_rdy;
    if_req_rdy = hs && (sel == ARB_ID_IF);
    ls_req_rdy = hs && (sel == ARB_ID_LS);
    push       = hs && !fifo_full;

    // Responses with nothing outstanding (e.g. stale after reset) are dropped.
    pop          = bus_rsp_vld && !fifo_empty;
    if_rsp_vld   = pop && (head_id == ARB_ID_IF);
    ls_rsp_vld   = pop && (head_id == ARB_ID_LS);
    if_rsp_rdata = if_rsp_vld ? bus_rsp_rdata : '0;
    ls_rsp_rdata = ls_rsp_vld ? bus_rsp_rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus_req_vld && !bus_req_rdy) begin
          state_d = ARB_HOLD;
          win_d   = sel;
        end
      end
      ARB_HOLD: begin
        if (bus_req_rdy) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      win_q   <= ARB_ID_IF;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  exu_mem_arb_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outst_cnt)
  );

endmodule

// File: tb/tb_exu_mem_arb.sv
// Directed bench for exu_mem_arb (default build; RR sequence enabled by EXU_MEM_ARB_RR_EN).
module tb_exu_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_vld, if_req_rdy, if_rsp_vld;
  logic [31:0] if_req_addr, if_rsp_rdata;
  logic        ls_req_vld, ls_req_rdy, ls_req_wr, ls_rsp_vld;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
  logic [3:0]  ls_req_wstrb;
  logic        bus_req_vld, bus_req_rdy, bus_req_wr, bus_rsp_vld;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
  logic [3:0]  bus_req_wstrb;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  exu_mem_arb #(.AW(32), .DW(32), .MAX_OUTST(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_vld    (if_req_vld),
    .if_req_rdy    (if_req_rdy),
    .if_req_addr   (if_req_addr),
    .if_rsp_vld    (if_rsp_vld),
    .if_rsp_rdata  (if_rsp_rdata),
    .ls_req_vld    (ls_req_vld),
    .ls_req_rdy    (ls_req_rdy),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wr     (ls_req_wr),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wstrb  (ls_req_wstrb),
    .ls_rsp_vld    (ls_rsp_vld),
    .ls_rsp_rdata  (ls_rsp_rdata),
    .bus_req_vld   (bus_req_vld),
    .bus_req_rdy   (bus_req_rdy),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wr    (bus_req_wr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_rsp_vld   (bus_rsp_vld),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are changed just after an edge; outputs are sampled 1ns later.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_vld = 0; if_req_addr = '0;
    ls_req_vld = 0; ls_req_addr = '0; ls_req_wr = 0; ls_req_wdata = '0; ls_req_wstrb = '0;
    bus_req_rdy = 0; bus_rsp_vld = 0; bus_rsp_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_bus_vld", 32'(bus_req_vld), 32'd0);
    chk("rst_rdy", {30'd0, if_req_rdy, ls_req_rdy}, 32'd0);
    chk("rst_rsp", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd0);

    // 1: simultaneous requests, LS wins first
    if_req_vld = 1; if_req_addr = 32'h100;
    ls_req_vld = 1; ls_req_addr = 32'h200; ls_req_wdata = 32'hDEADBEEF; ls_req_wstrb = 4'hF;
    bus_req_rdy = 1;
    #1;
    chk("t1_addr_ls", bus_req_addr, 32'h200);
    chk("t1_rdy_ls", {30'd0, if_req_rdy, ls_req_rdy}, 32'd1);
    tick();
    ls_req_vld = 0;
    #1;
    chk("t1_addr_if", bus_req_addr, 32'h100);
    chk("t1_rdy_if", {30'd0, if_req_rdy, ls_req_rdy}, 32'd2);
    chk("t1_if_wdata", bus_req_wdata, 32'd0);
    chk("t1_if_wstrb", 32'(bus_req_wstrb), 32'd0);
    tick();
    if_req_vld = 0;
    bus_rsp_vld = 1; bus_rsp_rdata = 32'hAAAA0001;
    #1;
    chk("t1_rsp0_vld", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd1);
    chk("t1_rsp0_data", ls_rsp_rdata, 32'hAAAA0001);
    tick();
    bus_rsp_rdata = 32'hBBBB0002;
    #1;
    chk("t1_rsp1_vld", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd2);
    chk("t1_rsp1_data", if_rsp_rdata, 32'hBBBB0002);
    tick();
    bus_rsp_vld = 0;

    // 2: IF held by bus backpressure while LS raises vld
    bus_req_rdy = 0;
    if_req_vld = 1; if_req_addr = 32'h300;
    #1;
    chk("t2_c0_addr", bus_req_addr, 32'h300);
    tick();
    ls_req_vld = 1; ls_req_addr = 32'h400;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("t2_hold_addr", bus_req_addr, 32'h300);
      chk("t2_hold_rdy", {30'd0, if_req_rdy, ls_req_rdy}, 32'd0);
      tick();
    end
    bus_req_rdy = 1;
    #1;
    chk("t2_c3_addr", bus_req_addr, 32'h300);
    chk("t2_c3_rdy", {30'd0, if_req_rdy, ls_req_rdy}, 32'd2);
    tick();
    if_req_vld = 0;
    #1;
    chk("t2_ls_addr", bus_req_addr, 32'h400);
    chk("t2_ls_rdy", {30'd0, if_req_rdy, ls_req_rdy}, 32'd1);
    tick();
    ls_req_vld = 0;
    bus_rsp_vld = 1; bus_rsp_rdata = 32'h3;
    #1;
    chk("t2_rsp_if", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd2);
    tick();
    #1;
    chk("t2_rsp_ls", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd1);
    tick();
    bus_rsp_vld = 0;

    // 3: three back-to-back IF reads against MAX_OUTST=2
    if_req_vld = 1; if_req_addr = 32'h500;
    #1;
    chk("t3_r0_rdy", 32'(if_req_rdy), 32'd1);
    tick();
    if_req_addr = 32'h504;
    #1;
    chk("t3_r1_rdy", 32'(if_req_rdy), 32'd1);
    tick();
    if_req_addr = 32'h508;
    #1;
    chk("t3_full_rdy", 32'(if_req_rdy), 32'd0);
    chk("t3_full_bvld", 32'(bus_req_vld), 32'd0);
    tick();
    bus_rsp_vld = 1; bus_rsp_rdata = 32'h11;
    #1;
    chk("t3_pop_rsp", 32'(if_rsp_vld), 32'd1);
    chk("t3_no_bypass", 32'(if_req_rdy), 32'd0);
    tick();
    bus_rsp_vld = 0;
    #1;
    chk("t3_r2_rdy", 32'(if_req_rdy), 32'd1);
    chk("t3_r2_addr", bus_req_addr, 32'h508);
    tick();
    if_req_vld = 0;
    bus_rsp_vld = 1; bus_rsp_rdata = 32'h22;
    #1;
    chk("t3_drain0", 32'(if_rsp_vld), 32'd1);
    tick();
    #1;
    chk("t3_drain1", 32'(if_rsp_vld), 32'd1);
    tick();
    bus_rsp_vld = 0;
    #1;
    chk("t3_empty_rsp", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd0);

    // 4: store pass-through and ack routing
    ls_req_vld = 1; ls_req_wr = 1; ls_req_addr = 32'h600;
    ls_req_wdata = 32'h12345678; ls_req_wstrb = 4'h3;
    #1;
    chk("t4_wr", 32'(bus_req_wr), 32'd1);
    chk("t4_wdata", bus_req_wdata, 32'h12345678);
    chk("t4_wstrb", 32'(bus_req_wstrb), 32'h3);
    chk("t4_rdy", 32'(ls_req_rdy), 32'd1);
    tick();
    ls_req_vld = 0; ls_req_wr = 0;
    bus_rsp_vld = 1; bus_rsp_rdata = '0;
    #1;
    chk("t4_ack", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd1);
    tick();
    bus_rsp_vld = 0;

    // 5: reset with two outstanding, then stale response
    if_req_vld = 1; if_req_addr = 32'h700;
    tick(); tick();
    if_req_vld = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("t5_bus_vld", 32'(bus_req_vld), 32'd0);
    chk("t5_bus_addr", bus_req_addr, 32'd0);
    bus_rsp_vld = 1; bus_rsp_rdata = 32'hCAFE;
    #1;
    chk("t5_stale_rsp", {30'd0, if_rsp_vld, ls_rsp_vld}, 32'd0);
    chk("t5_stale_data", if_rsp_rdata | ls_rsp_rdata, 32'd0);
    tick();
    bus_rsp_vld = 0;
    if_req_vld = 1; if_req_addr = 32'h800;
    #1;
    chk("t5_cnt0_a", 32'(if_req_rdy), 32'd1);
    tick();
    #1;
    chk("t5_cnt0_b", 32'(if_req_rdy), 32'd1);
    tick();
    if_req_vld = 0;
    bus_rsp_vld = 1;
    tick(); tick();
    bus_rsp_vld = 0;

`ifdef EXU_MEM_ARB_RR_EN
    // 6: a lone IF grant points RR at LS, then both valid alternate
    if_req_vld = 1; if_req_addr = 32'h900;
    tick();
    if_req_vld = 0;
    bus_rsp_vld = 1;
    tick();
    bus_rsp_vld = 0;
    if_req_vld = 1; ls_req_vld = 1; ls_req_addr = 32'hA00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_rr", {30'd0, if_req_rdy, ls_req_rdy}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      bus_rsp_vld = 1;
    end
    if_req_vld = 0; ls_req_vld = 0;
    tick();
    bus_rsp_vld = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
